axis_demux_1to8: RTL
====================

Name: axis_demux_1to8

Overview:
- AXI-Stream 1-to-8 packet distributor: routes one slave stream to one of eight master channels.
- Destination channel is latched per packet. Once a packet starts, every beat up to and including its TLAST goes to that same channel.
- Sits in the AXI control wrapper, opposite the 8-to-1 output mux. It steers DMA-fed words into eight per-bank write ports.
- One registered output stage provides full-throughput valid/ready handshaking and per-packet beat accounting.

Parameters:
- DATA_WIDTH, 16, width of the stream data word.
- CNT_WIDTH, 16, width of the per-packet beat counter.

Ports:
- aclk  in  1  clock; all logic on the rising edge.
- aresetn  in  1  synchronous, active-low reset.
- sel  in  3  destination channel; sampled only on the first beat of a packet.
- s_tdata  in  DATA_WIDTH  slave data.
- s_tvalid  in  1  slave valid.
- s_tlast  in  1  slave end-of-packet.
- s_tready  out  1  slave ready.
- m_tdata  out  DATA_WIDTH  master data, shared by all 8 channels.
- m_tlast  out  1  master end-of-packet, shared.
- m_tvalid  out  8  one-hot master valid; bit i = channel i.
- m_tready  in  8  per-channel master ready.
- active_ch  out  3  channel latched for the packet in progress.
- busy  out  1  high while a packet is open (first beat accepted, TLAST not yet accepted).
- pkt_done  out  1  one-cycle pulse after a TLAST beat is accepted on the slave side.
- pkt_beats  out  CNT_WIDTH  beat count of the last completed packet; valid when pkt_done is high, held until the next completion.

Behaviour:
- Reset (aresetn low at a clock edge), regardless of any transfer in flight:
  - state = IDLE; output register empty.
  - Outputs: m_tvalid = 0, m_tdata = 0, m_tlast = 0, active_ch = 0, busy = 0, pkt_done = 0, pkt_beats = 0.
  - Beat counter = 0.
  - s_tready = 0 while reset is asserted.
  - A partially forwarded packet is dropped silently; there is no recovery beat.
- Internal output register holds: data, last, out_ch (3 b), out_valid.
- Routing (combinational from registers):
  - m_tvalid[i] = out_valid && (out_ch == i).
  - m_tdata = data; m_tlast = last.
- Ready:
  - s_tready = aresetn && (!out_valid || m_tready[out_ch]).
  - Gives one-beat-per-cycle throughput while the destination is ready.
  - No combinational path from s_tvalid to s_tready.
  - m_tready bits of non-selected channels are ignored.
- Accept (s_tvalid && s_tready):
  - Load data <= s_tdata, last <= s_tlast, out_valid <= 1.
  - out_ch <= (state == IDLE) ? sel : active_ch.
- Drain: if out_valid && m_tready[out_ch] with no accept that cycle, out_valid <= 0.
- Latency: input beat accepted at edge N appears on the master side from cycle N+1; held stable until the master handshake.
- FSM:
  - IDLE, accept with s_tlast = 0 -> ROUTE: active_ch <= sel, busy <= 1, counter <= 1.
  - IDLE, accept with s_tlast = 1 -> stays IDLE (single-beat packet): active_ch <= sel, pkt_beats <= 1, pkt_done <= 1.
  - ROUTE, accept with s_tlast = 0: counter <= counter + 1.
  - ROUTE, accept with s_tlast = 1 -> IDLE: pkt_beats <= counter + 1, pkt_done <= 1, busy <= 0, counter <= 0.
- sel changes while in ROUTE are ignored. A new packet may begin on the cycle immediately after its predecessor's TLAST accept. Its first beat can route to a different channel even while the old TLAST beat is still in the output register; out_ch tags each beat individually.
- Counter saturates at 2^CNT_WIDTH-1 and does not wrap; pkt_beats reports the saturated value.
- pkt_done is high for exactly one cycle per packet, asserted the cycle after the TLAST accept, independent of master-side drain.
- s_tvalid low mid-packet: no state change; partial-packet state is held indefinitely.
- Stall: m_tready[out_ch] low with out_valid high -> s_tready = 0; output register contents held unchanged (AXI-Stream stability rule).

Test Plan:
- Reset/idle: hold aresetn low 3 cycles with s_tvalid = 1 -> s_tready = 0, m_tvalid = 8'h00, pkt_beats = 0. Release -> s_tready = 1.
- Single packet: sel = 5; send 4 beats 0x0001..0x0004, TLAST on beat 4; all m_tready = 1 -> m_tvalid = 8'h20 for 4 consecutive cycles starting 1 cycle after the first accept; m_tlast on 0x0004; pkt_done pulse with pkt_beats = 4; busy high for beats 1-3 only.
- Mid-packet sel change: sel = 2 at beat 1, then sel = 7 during beats 2-3 of a 3-beat packet -> all beats on channel 2 (m_tvalid = 8'h04); active_ch = 2 throughout.
- Back-to-back packets with backpressure: packet A (2 beats, sel = 1) then packet B (1 beat, sel = 6) with no gap; m_tready[1] low for 3 cycles while the A TLAST beat is held -> s_tready = 0 and A's data stable during the stall. After release, B's beat appears on m_tvalid = 8'h40. Two pkt_done pulses with pkt_beats 2 then 1.
- Non-selected ready ignored: sel = 3; m_tready = 8'hF7 (bit 3 low) -> first beat held, s_tready = 0, no beat lost. Raising bit 3 drains it.
- Reset mid-packet: assert aresetn low after beat 2 of a 5-beat packet -> next cycle m_tvalid = 0, busy = 0, counter cleared. A following 1-beat packet with sel = 0 gives pkt_beats = 1.

Source files
------------

// File: rtl/axis_demux_1to8.sv
// AXI-Stream 1-to-8 packet distributor: the destination is latched on the first
// beat of each packet and every beat goes through a single registered output stage.
module axis_demux_1to8 #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [2:0]            sel,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  input  logic                  s_tlast,
  output logic                  s_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tlast,
  output logic [7:0]            m_tvalid,
  input  logic [7:0]            m_tready,
  output logic [2:0]            active_ch,
  output logic                  busy,
  output logic                  pkt_done,
  output logic [CNT_WIDTH-1:0]  pkt_beats
);

  // state | meaning
  // IDLE  | no packet open; the next accepted beat samples sel
  // ROUTE | packet open; beats follow active_ch until TLAST is accepted
  typedef enum logic {IDLE, ROUTE} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  last_q, last_d;
  logic [2:0]            out_ch_q, out_ch_d;
  logic                  out_valid_q, out_valid_d;
  logic [2:0]            active_ch_q, active_ch_d;
  logic                  busy_q, busy_d;
  logic                  pkt_done_q, pkt_done_d;
  logic [CNT_WIDTH-1:0]  pkt_beats_q, pkt_beats_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic                  accept;
  logic                  drain;
  logic [CNT_WIDTH-1:0]  cnt_inc;

  // Ready depends only on registered state and m_tready, never on s_tvalid.
  assign drain    = out_valid_q && m_tready[out_ch_q];
  assign s_tready = aresetn && (!out_valid_q || m_tready[out_ch_q]);
  assign accept   = s_tvalid && s_tready;
  assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    last_d      = last_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    active_ch_d = active_ch_q;
    busy_d      = busy_q;
    pkt_done_d  = 1'b0;
    pkt_beats_d = pkt_beats_q;
    cnt_d       = cnt_q;

    if (accept) begin
      data_d      = s_tdata;
      last_d      = s_tlast;
      out_valid_d = 1'b1;
      out_ch_d    = (state_q == IDLE) ? sel : active_ch_q;
    end else if (drain) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          active_ch_d = sel;
          if (s_tlast) begin
            pkt_beats_d = CNT_WIDTH'(1);
            pkt_done_d  = 1'b1;
          end else begin
            state_d = ROUTE;
            busy_d  = 1'b1;
            cnt_d   = CNT_WIDTH'(1);
          end
        end
      end
      ROUTE: begin
        if (accept) begin
          if (s_tlast) begin
            state_d     = IDLE;
            pkt_beats_d = cnt_inc;
            pkt_done_d  = 1'b1;
            busy_d      = 1'b0;
            cnt_d       = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      data_q      <= '0;
      last_q      <= 1'b0;
      out_ch_q    <= 3'd0;
      out_valid_q <= 1'b0;
      active_ch_q <= 3'd0;
      busy_q      <= 1'b0;
      pkt_done_q  <= 1'b0;
      pkt_beats_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      last_q      <= last_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      active_ch_q <= active_ch_d;
      busy_q      <= busy_d;
      pkt_done_q  <= pkt_done_d;
      pkt_beats_q <= pkt_beats_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    m_tvalid           = 8'h00;
    m_tvalid[out_ch_q] = out_valid_q;
  end

  assign m_tdata   = data_q;
  assign m_tlast   = last_q;
  assign active_ch = active_ch_q;
  assign busy      = busy_q;
  assign pkt_done  = pkt_done_q;
  assign pkt_beats = pkt_beats_q;

endmodule
